// File: rtl/ahb_burst_ctrl_if.sv
// AHB-Lite encodings (ahb_types_pkg) and the command/bus interface of the
// ahb_burst_ctrl address-phase controller.
package ahb_types_pkg;
   typedef enum logic [2:0] {
      BURST_SINGLE = 3'd0,
      BURST_INCR   = 3'd1,
      BURST_WRAP4  = 3'd2,
      BURST_INCR4  = 3'd3,
      BURST_WRAP8  = 3'd4,
      BURST_INCR8  = 3'd5,
      BURST_WRAP16 = 3'd6,
      BURST_INCR16 = 3'd7
   } burst_t;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2,
      SIZE_ERR  = 2'd3
   } size_t;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'd0,
      TRANS_BUSY   = 2'd1,
      TRANS_NONSEQ = 2'd2,
      TRANS_SEQ    = 2'd3
   } transfer_t;

   typedef enum logic {RW_READ = 1'b0, RW_WRITE = 1'b1} rw_t;
   typedef enum logic {RESP_OKAY = 1'b0, RESP_ERROR = 1'b1} resp_t;
endpackage

interface ahb_burst_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [2:0]        cmd_burst;
   logic [1:0]        cmd_size;
   logic              cmd_write;
   logic [LEN_W-1:0]  cmd_len;
   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic [2:0]        HBURST;
   logic [2:0]        HSIZE;
   logic              HWRITE;
   logic              HREADY;
   logic              HRESP;
   logic              done;
   logic              err;

   modport master (
      input  cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_write, cmd_len,
      input  HREADY, HRESP,
      output cmd_ready, HADDR, HTRANS, HBURST, HSIZE, HWRITE, done, err
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_write, cmd_len,
      output HREADY, HRESP,
      input  cmd_ready, HADDR, HTRANS, HBURST, HSIZE, HWRITE, done, err
   );
endinterface

// File: rtl/ahb_burst_ctrl.sv
// AHB-Lite master address-phase controller: one command in, NONSEQ/SEQ beats out.
// Define AHB_ERR_ABORT_EN to cancel remaining beats on the first ERROR cycle.
module ahb_burst_ctrl #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   ahb_burst_ctrl_if.master bus
);
   import ahb_types_pkg::*;

   localparam int CNT_W = (LEN_W + 1 > 5) ? LEN_W + 1 : 5;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST} state_t;

   state_t            state;
   logic [CNT_W-1:0]  beats_left;
   logic [ADDR_W-1:0] wrap_mask;
   logic              err_sticky;

   logic [CNT_W-1:0]  cmd_beats;
   logic [ADDR_W-1:0] cmd_step;
   logic [ADDR_W-1:0] cmd_aligned;
   logic [ADDR_W-1:0] cmd_end;
   logic [ADDR_W-1:0] cmd_mask;
   logic              cmd_bad;
   logic [ADDR_W-1:0] step;
   logic [ADDR_W-1:0] next_addr;
   logic              next_cross;

   assign bus.cmd_ready = (state == S_IDLE);

   // Command decode, evaluated while idle and consumed on accept.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      cmd_beats = CNT_W'(1);
      case (bus.cmd_burst)
         BURST_INCR:                cmd_beats = CNT_W'(bus.cmd_len) + CNT_W'(1);
         BURST_WRAP4,  BURST_INCR4: cmd_beats = CNT_W'(4);
         BURST_WRAP8,  BURST_INCR8: cmd_beats = CNT_W'(8);
         BURST_WRAP16, BURST_INCR16: cmd_beats = CNT_W'(16);
         default:                   cmd_beats = CNT_W'(1);
      endcase
      cmd_step    = ADDR_W'(1) << bus.cmd_size;
      cmd_aligned = bus.cmd_addr & ~(cmd_step - ADDR_W'(1));
      cmd_end     = cmd_aligned + ((ADDR_W'(cmd_beats) - ADDR_W'(1)) << bus.cmd_size);
      // An all-ones mask turns the wrap formula into a plain increment.
      cmd_mask = '1;
      if (bus.cmd_burst inside {BURST_WRAP4, BURST_WRAP8, BURST_WRAP16})
         cmd_mask = (ADDR_W'(cmd_beats) << bus.cmd_size) - ADDR_W'(1);
      cmd_bad = (bus.cmd_size == SIZE_ERR) ||
                ((bus.cmd_burst inside {BURST_INCR4, BURST_INCR8, BURST_INCR16}) &&
                 (cmd_end[ADDR_W-1:10] != cmd_aligned[ADDR_W-1:10]));
   end

   always_comb begin
      step       = ADDR_W'(1) << bus.HSIZE[1:0];
      next_addr  = (bus.HADDR & ~wrap_mask) | ((bus.HADDR + step) & wrap_mask);
      next_cross = (bus.HBURST == BURST_INCR) &&
                   (next_addr[ADDR_W-1:10] != bus.HADDR[ADDR_W-1:10]);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= S_IDLE;
         beats_left <= '0;
         wrap_mask  <= '0;
         err_sticky <= 1'b0;
         bus.HADDR  <= '0;
         bus.HTRANS <= TRANS_IDLE;
         bus.HBURST <= BURST_SINGLE;
         bus.HSIZE  <= 3'd0;
         bus.HWRITE <= 1'b0;
         bus.done   <= 1'b0;
         bus.err    <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  if (cmd_bad) begin
                     bus.done <= 1'b1;
                     bus.err  <= 1'b1;
                  end else begin
                     state      <= S_ADDR;
                     beats_left <= cmd_beats;
                     wrap_mask  <= cmd_mask;
                     err_sticky <= 1'b0;
                     bus.HADDR  <= cmd_aligned;
                     bus.HTRANS <= TRANS_NONSEQ;
                     bus.HBURST <= bus.cmd_burst;
                     bus.HSIZE  <= {1'b0, bus.cmd_size};
                     bus.HWRITE <= bus.cmd_write;
                  end
               end
            end

            S_ADDR: begin
               if (bus.HRESP) err_sticky <= 1'b1;
`ifdef AHB_ERR_ABORT_EN
               if (bus.HRESP && !bus.HREADY) begin
                  bus.HTRANS <= TRANS_IDLE;
                  state      <= S_LAST;
               end else
`endif
               if (bus.HREADY) begin
                  if (beats_left == CNT_W'(1)) begin
                     bus.HTRANS <= TRANS_IDLE;
                     state      <= S_LAST;
                  end else begin
                     beats_left <= beats_left - CNT_W'(1);
                     bus.HADDR  <= next_addr;
                     // Undefined-length INCR restarts as NONSEQ across a 1KB line.
                     bus.HTRANS <= next_cross ? TRANS_NONSEQ : TRANS_SEQ;
                  end
               end
            end

            S_LAST: begin
               if (bus.HRESP) err_sticky <= 1'b1;
               if (bus.HREADY) begin
                  bus.done <= 1'b1;
                  bus.err  <= err_sticky | bus.HRESP;
                  state    <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ahb_burst_ctrl.sv
// Directed bench for ahb_burst_ctrl; honours AHB_ERR_ABORT_EN like the RTL.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ahb_burst_ctrl;
   import ahb_types_pkg::*;

   logic HCLK = 1'b0;
   logic HRESETn;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 HCLK = ~HCLK;

   ahb_burst_ctrl_if #(.ADDR_W(32), .LEN_W(8)) bus ();

   ahb_burst_ctrl #(.ADDR_W(32), .LEN_W(8)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic issue(input logic [31:0] addr, input logic [2:0] burst,
                        input logic [1:0] size, input logic write, input logic [7:0] len);
      check("cmd_ready before accept", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = addr;
      bus.cmd_burst = burst;
      bus.cmd_size  = size;
      bus.cmd_write = write;
      bus.cmd_len   = len;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic beat(input string tag, input logic [31:0] addr, input logic [1:0] trans);
      check({tag, " HTRANS"}, 32'(bus.HTRANS), 32'(trans));
      check({tag, " HADDR"},  bus.HADDR, addr);
      tick();
   endtask

   task automatic finish_burst(input string tag, input logic exp_err);
      check({tag, " trailing IDLE"}, 32'(bus.HTRANS), 32'(TRANS_IDLE));
      check({tag, " no early done"}, 32'(bus.done), 32'd0);
      tick();
      check({tag, " done"}, 32'(bus.done), 32'd1);
      check({tag, " err"},  32'(bus.err), 32'(exp_err));
      tick();
      check({tag, " done pulse ends"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      HRESETn       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_burst = '0;
      bus.cmd_size  = '0;
      bus.cmd_write = 1'b0;
      bus.cmd_len   = '0;
      bus.HREADY    = 1'b1;
      bus.HRESP     = 1'b0;
      tick();
      check("reset HTRANS", 32'(bus.HTRANS), 32'(TRANS_IDLE));
      check("reset HADDR",  bus.HADDR, 32'h0);
      check("reset HBURST", 32'(bus.HBURST), 32'(BURST_SINGLE));
      check("reset HSIZE",  32'(bus.HSIZE), 32'd0);
      check("reset HWRITE", 32'(bus.HWRITE), 32'd0);
      check("reset done",   32'(bus.done), 32'd0);
      check("reset err",    32'(bus.err), 32'd0);
      HRESETn = 1'b1;
      tick();

      // SINGLE WORD write at 0x100
      issue(32'h100, BURST_SINGLE, SIZE_WORD, 1'b1, 8'd0);
      check("single HWRITE",    32'(bus.HWRITE), 32'd1);
      check("single HSIZE",     32'(bus.HSIZE), 32'd2);
      check("single HBURST",    32'(bus.HBURST), 32'(BURST_SINGLE));
      check("single cmd_ready", 32'(bus.cmd_ready), 32'd0);
      beat("single b0", 32'h100, TRANS_NONSEQ);
      finish_burst("single", 1'b0);

      // WRAP4 WORD at 0x38
      issue(32'h38, BURST_WRAP4, SIZE_WORD, 1'b0, 8'd0);
      check("wrap4 HBURST", 32'(bus.HBURST), 32'(BURST_WRAP4));
      beat("wrap4 b0", 32'h38, TRANS_NONSEQ);
      beat("wrap4 b1", 32'h3C, TRANS_SEQ);
      beat("wrap4 b2", 32'h30, TRANS_SEQ);
      beat("wrap4 b3", 32'h34, TRANS_SEQ);
      finish_burst("wrap4", 1'b0);

      // WRAP8 BYTE at 0x1D wraps inside the 8-byte block 0x18..0x1F
      issue(32'h1D, BURST_WRAP8, SIZE_BYTE, 1'b0, 8'd0);
      beat("wrap8 b0", 32'h1D, TRANS_NONSEQ);
      beat("wrap8 b1", 32'h1E, TRANS_SEQ);
      beat("wrap8 b2", 32'h1F, TRANS_SEQ);
      beat("wrap8 b3", 32'h18, TRANS_SEQ);
      beat("wrap8 b4", 32'h19, TRANS_SEQ);
      beat("wrap8 b5", 32'h1A, TRANS_SEQ);
      beat("wrap8 b6", 32'h1B, TRANS_SEQ);
      beat("wrap8 b7", 32'h1C, TRANS_SEQ);
      finish_burst("wrap8", 1'b0);

      // INCR8 HALFWORD at 0x0, two wait states on the third beat
      issue(32'h0, BURST_INCR8, SIZE_HALF, 1'b1, 8'd0);
      beat("incr8 b0", 32'h0, TRANS_NONSEQ);
      beat("incr8 b1", 32'h2, TRANS_SEQ);
      bus.HREADY = 1'b0;
      beat("incr8 b2 wait1", 32'h4, TRANS_SEQ);
      beat("incr8 b2 wait2", 32'h4, TRANS_SEQ);
      bus.HREADY = 1'b1;
      beat("incr8 b2", 32'h4, TRANS_SEQ);
      beat("incr8 b3", 32'h6, TRANS_SEQ);
      beat("incr8 b4", 32'h8, TRANS_SEQ);
      beat("incr8 b5", 32'hA, TRANS_SEQ);
      beat("incr8 b6", 32'hC, TRANS_SEQ);
      beat("incr8 b7", 32'hE, TRANS_SEQ);
      finish_burst("incr8", 1'b0);

      // Unaligned INCR4 HALFWORD read at 0x201 is aligned to 0x200
      issue(32'h201, BURST_INCR4, SIZE_HALF, 1'b0, 8'd0);
      check("align HSIZE", 32'(bus.HSIZE), 32'd1);
      beat("align b0", 32'h200, TRANS_NONSEQ);
      beat("align b1", 32'h202, TRANS_SEQ);
      beat("align b2", 32'h204, TRANS_SEQ);
      beat("align b3", 32'h206, TRANS_SEQ);
      finish_burst("align", 1'b0);

      // INCR len=3 BYTE at 0x3FE crosses the 1KB line after two beats
      issue(32'h3FE, BURST_INCR, SIZE_BYTE, 1'b0, 8'd3);
      check("incr HBURST", 32'(bus.HBURST), 32'(BURST_INCR));
      beat("incr b0", 32'h3FE, TRANS_NONSEQ);
      beat("incr b1", 32'h3FF, TRANS_SEQ);
      beat("incr b2", 32'h400, TRANS_NONSEQ);
      check("incr HBURST after 1KB", 32'(bus.HBURST), 32'(BURST_INCR));
      beat("incr b3", 32'h401, TRANS_SEQ);
      finish_burst("incr", 1'b0);

      // Illegal size: no bus activity, done+err the cycle after accept
      issue(32'h40, BURST_INCR4, SIZE_ERR, 1'b0, 8'd0);
      check("badsize HTRANS", 32'(bus.HTRANS), 32'(TRANS_IDLE));
      check("badsize done",   32'(bus.done), 32'd1);
      check("badsize err",    32'(bus.err), 32'd1);
      tick();
      check("badsize done ends", 32'(bus.done), 32'd0);
      check("badsize ready",     32'(bus.cmd_ready), 32'd1);

      // Fixed INCR4 WORD at 0x3F8 would cross 1KB: command error
      issue(32'h3F8, BURST_INCR4, SIZE_WORD, 1'b0, 8'd0);
      check("cross1k HTRANS", 32'(bus.HTRANS), 32'(TRANS_IDLE));
      check("cross1k done",   32'(bus.done), 32'd1);
      check("cross1k err",    32'(bus.err), 32'd1);
      tick();

      // INCR4 WORD at 0x0 with a two-cycle ERROR on the data phase of 0x4
      issue(32'h0, BURST_INCR4, SIZE_WORD, 1'b1, 8'd0);
      beat("error b0", 32'h0, TRANS_NONSEQ);
      beat("error b1", 32'h4, TRANS_SEQ);
      bus.HRESP  = 1'b1;
      bus.HREADY = 1'b0;
      beat("error b2 held", 32'h8, TRANS_SEQ);
      bus.HREADY = 1'b1;
`ifdef AHB_ERR_ABORT_EN
      check("abort HTRANS", 32'(bus.HTRANS), 32'(TRANS_IDLE));
      check("abort no early done", 32'(bus.done), 32'd0);
      tick();
      bus.HRESP = 1'b0;
      check("abort done", 32'(bus.done), 32'd1);
      check("abort err",  32'(bus.err), 32'd1);
      tick();
      check("abort done ends", 32'(bus.done), 32'd0);
`else
      beat("error b2", 32'h8, TRANS_SEQ);
      bus.HRESP = 1'b0;
      beat("error b3", 32'hC, TRANS_SEQ);
      finish_burst("error", 1'b1);
`endif
      check("error ready", 32'(bus.cmd_ready), 32'd1);

      // A clean burst afterwards must not inherit the old error
      issue(32'h80, BURST_SINGLE, SIZE_WORD, 1'b0, 8'd0);
      beat("clean b0", 32'h80, TRANS_NONSEQ);
      finish_burst("clean", 1'b0);

      // Asynchronous reset in the middle of a burst
      issue(32'h200, BURST_INCR4, SIZE_WORD, 1'b1, 8'd0);
      beat("rst b0", 32'h200, TRANS_NONSEQ);
      HRESETn = 1'b0;
      #1;
      check("midrst HTRANS", 32'(bus.HTRANS), 32'(TRANS_IDLE));
      check("midrst HADDR",  bus.HADDR, 32'h0);
      check("midrst HBURST", 32'(bus.HBURST), 32'(BURST_SINGLE));
      check("midrst HWRITE", 32'(bus.HWRITE), 32'd0);
      check("midrst ready",  32'(bus.cmd_ready), 32'd1);
      HRESETn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("midrst no done", 32'(bus.done), 32'd0);
         check("midrst idle",    32'(bus.HTRANS), 32'(TRANS_IDLE));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
